biquad8_coeff_sequencer: RTL and testbench
==========================================

BIQUAD8_COEFF_SEQUENCER -- requirements
Module: biquad8_coeff_sequencer

Interface
REQ-001 SHALL have parameter NCOEFF, default 2, number of coefficient words per set (2 for the zero FIR: b then a).
REQ-002 SHALL have parameter COEFF_BITS, default 18, coefficient word width.
REQ-003 SHALL have parameter SETTLE_CYCLES, default 3, post-update quiet cycles covering the filter's 3-clock bypass/update delay.
REQ-004 SHALL have port clk  input  1  sole clock.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port s_coeff_tdata  input  COEFF_BITS  incoming coefficient word.
REQ-007 SHALL have port s_coeff_tvalid  input  1  word valid.
REQ-008 SHALL have port s_coeff_tlast  input  1  last word of a set.
REQ-009 SHALL have port s_coeff_tready  output  1  sequencer accepts the word.
REQ-010 SHALL have port bypass_req_i  input  1  requested filter bypass.
REQ-011 SHALL have port coeff_dat_o  output  COEFF_BITS  coefficient data to filter.
REQ-012 SHALL have port coeff_wr_o  output  1  one-cycle coefficient write strobe.
REQ-013 SHALL have port coeff_update_o  output  1  one-cycle coefficient commit strobe.
REQ-014 SHALL have port bypass_o  output  1  registered bypass to filter.
REQ-015 SHALL have port busy_o  output  1  set in flight (WRITE/UPDATE/SETTLE).
REQ-016 SHALL have port done_o  output  1  one-cycle pulse, set committed and settled.
REQ-017 SHALL have port err_o  output  1  one-cycle pulse, malformed set discarded.

Function
REQ-018 SHALL implement states FILL, DROP, WRITE, UPDATE, SETTLE; reset state FILL.
REQ-019 Handshake: word transfers when tvalid and tready are both high; tready SHALL be high only in FILL and DROP.
REQ-020 FILL: words stored in staging slots 0..NCOEFF-1 in arrival order; index increments per transfer.
REQ-021 FILL, transfer with tlast at index NCOEFF-1: SHALL go to WRITE next cycle.
REQ-022 FILL, transfer with tlast at index < NCOEFF-1 (short set): SHALL discard, pulse err_o next cycle, reset index, stay FILL.
REQ-023 FILL, transfer at index NCOEFF-1 without tlast (long set): SHALL go to DROP; DROP accepts and discards words until a tlast transfer, then pulses err_o next cycle and returns to FILL with index 0.
REQ-024 WRITE: if the final tlast transfer is at cycle T, SHALL present slot k on coeff_dat_o with coeff_wr_o high at cycle T+1+k, k=0..NCOEFF-1, on consecutive cycles.
REQ-025 UPDATE: coeff_update_o SHALL be high for exactly cycle T+NCOEFF+1, with coeff_wr_o low.
REQ-026 SETTLE: SHALL hold SETTLE_CYCLES cycles after UPDATE; done_o pulses on the last SETTLE cycle; FILL (tready high) resumes the following cycle.
REQ-027 busy_o SHALL be high exactly during WRITE, UPDATE and SETTLE.
REQ-028 coeff_dat_o SHALL hold its last written value when coeff_wr_o is low; coeff_wr_o and coeff_update_o SHALL never be high in the same cycle.
REQ-029 bypass_o SHALL equal bypass_req_i delayed one clk in every state; bypass SHALL be independent of the coefficient sequence.
REQ-030 Staging SHALL be double-use-safe: no new word is accepted until SETTLE completes, so slot contents stay stable during WRITE.

Reset
REQ-031 On rst high at a clock edge: state FILL, index 0, staging cleared to 0, coeff_dat_o=0, coeff_wr_o=0, coeff_update_o=0, busy_o=0, done_o=0, err_o=0, bypass_o=1, s_coeff_tready=0 that cycle.
REQ-032 rst asserted mid-WRITE/UPDATE/SETTLE SHALL abort; no strobe is emitted on any cycle after the reset edge until a new complete set arrives.

Structure
REQ-033 COEFF_BITS default and the state enumeration SHALL live in shared package biquad_pkg.
REQ-034 SHALL be a single module with no sub-modules; staging is a NCOEFF x COEFF_BITS register array.

Verification
REQ-035 Set b=18'h0C000, a=18'h02000 with tlast on a at cycle T -> wr at T+1 (dat 0C000), T+2 (dat 02000), update at T+3, done at T+6, tready back high at T+7.
REQ-036 Single word 18'h01234 with tlast -> no wr/update, err_o pulse one cycle later, next valid 2-word set commits normally.
REQ-037 Three words without tlast until the third -> words absorbed in DROP, err_o after third, no strobes emitted.
REQ-038 tvalid held high with a second set queued during WRITE/SETTLE -> tready low throughout; second set accepted only after done_o, committed intact.
REQ-039 rst pulsed on cycle T+2 of REQ-035 sequence -> no update strobe, all outputs at reset values, bypass_o=1.
REQ-040 bypass_req_i toggled 0->1->0 at arbitrary cycles during a sequence -> bypass_o follows exactly one cycle later; coefficient timing unchanged.

Source files
------------

// File: rtl/biquad_pkg.sv
// Shared definitions for the biquad coefficient path.
//
// Contents:
//   CoeffBitsDefault - default coefficient word width
//   seq_state_e      - coefficient sequencer state enumeration
package biquad_pkg;

    localparam int unsigned CoeffBitsDefault = 18;

    typedef enum logic [2:0] {
        StFill,
        StDrop,
        StWrite,
        StUpdate,
        StSettle
    } seq_state_e;

endpackage

// File: rtl/biquad8_coeff_sequencer.sv
// Coefficient sequencer for a biquad section.
//
// Collects one coefficient set from an AXI-stream style input into staging
// registers. A well-formed set is written to the filter one word per cycle,
// followed by a single commit strobe and a quiet settle window. Malformed
// sets (too short or too long) are discarded and reported with err_o.
//
// Ports:
//   clk             - sole clock
//   rst             - synchronous active-high reset
//   s_coeff_tdata   - incoming coefficient word
//   s_coeff_tvalid  - word valid
//   s_coeff_tlast   - last word of a set
//   s_coeff_tready  - sequencer accepts the word (FILL/DROP only)
//   bypass_req_i    - requested filter bypass
//   coeff_dat_o     - coefficient data to filter, holds last written value
//   coeff_wr_o      - one-cycle write strobe per coefficient word
//   coeff_update_o  - one-cycle commit strobe
//   bypass_o        - bypass_req_i registered by one clock
//   busy_o          - set in flight (WRITE/UPDATE/SETTLE)
//   done_o          - pulse on the last settle cycle
//   err_o           - pulse one cycle after a malformed set ends
module biquad8_coeff_sequencer
    import biquad_pkg::*;
#(
    parameter int unsigned NCOEFF        = 2,
    parameter int unsigned COEFF_BITS    = CoeffBitsDefault,
    parameter int unsigned SETTLE_CYCLES = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [COEFF_BITS-1:0] s_coeff_tdata,
    input  logic                  s_coeff_tvalid,
    input  logic                  s_coeff_tlast,
    output logic                  s_coeff_tready,
    input  logic                  bypass_req_i,
    output logic [COEFF_BITS-1:0] coeff_dat_o,
    output logic                  coeff_wr_o,
    output logic                  coeff_update_o,
    output logic                  bypass_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o
);

    localparam int unsigned IdxW = (NCOEFF > 1) ? $clog2(NCOEFF) : 1;
    localparam int unsigned CntW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NCOEFF - 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(SETTLE_CYCLES - 1);

    seq_state_e state_q, state_d;

    logic [IdxW-1:0]       idx_q, idx_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  err_q, err_d;
    logic                  bypass_q;
    logic [COEFF_BITS-1:0] dat_q;
    logic [COEFF_BITS-1:0] stage_q [NCOEFF];
    logic                  xfer;

    assign xfer = s_coeff_tvalid && s_coeff_tready;

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StFill;
            idx_q    <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            bypass_q <= 1'b1;
            dat_q    <= '0;
            for (int i = 0; i < NCOEFF; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            bypass_q <= bypass_req_i;
            // Slots are only written while filling; during a long set the
            // overflowing words never reach staging because the state is DROP.
            if (state_q == StFill && xfer) begin
                stage_q[idx_q] <= s_coeff_tdata;
            end
            if (state_q == StWrite) begin
                dat_q <= stage_q[idx_q];
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        unique case (state_q)
            StFill: begin
                if (xfer) begin
                    if (s_coeff_tlast) begin
                        idx_d = '0;
                        if (idx_q == LastIdx) begin
                            state_d = StWrite;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else if (idx_q == LastIdx) begin
                        idx_d   = '0;
                        state_d = StDrop;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            StDrop: begin
                if (xfer && s_coeff_tlast) begin
                    err_d   = 1'b1;
                    state_d = StFill;
                end
            end
            StWrite: begin
                if (idx_q == LastIdx) begin
                    idx_d   = '0;
                    state_d = StUpdate;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StUpdate: begin
                cnt_d   = '0;
                state_d = StSettle;
            end
            StSettle: begin
                if (cnt_q == LastCnt) begin
                    cnt_d   = '0;
                    state_d = StFill;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StFill;
                idx_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs.
    always_comb begin
        s_coeff_tready = 1'b0;
        coeff_wr_o     = 1'b0;
        coeff_update_o = 1'b0;
        busy_o         = 1'b0;
        done_o         = 1'b0;
        unique case (state_q)
            StFill, StDrop: s_coeff_tready = !rst;
            StWrite: begin
                coeff_wr_o = 1'b1;
                busy_o     = 1'b1;
            end
            StUpdate: begin
                coeff_update_o = 1'b1;
                busy_o         = 1'b1;
            end
            StSettle: begin
                busy_o = 1'b1;
                done_o = (cnt_q == LastCnt);
            end
            default: ;
        endcase
        // Present the current slot while writing, otherwise hold the last word.
        coeff_dat_o = coeff_wr_o ? stage_q[idx_q] : dat_q;
        err_o       = err_q;
        bypass_o    = bypass_q;
    end

endmodule

// File: tb/tb_biquad8_coeff_sequencer.sv
module tb_biquad8_coeff_sequencer;

    localparam int NC = 2;
    localparam int CB = 18;
    localparam int SC = 3;

    localparam int KWr   = 0;
    localparam int KUpd  = 1;
    localparam int KDone = 2;
    localparam int KErr  = 3;

    typedef struct {
        int          cyc;
        int          kind;
        logic [CB-1:0] dat;
    } ev_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [CB-1:0] s_coeff_tdata;
    logic          s_coeff_tvalid;
    logic          s_coeff_tlast;
    logic          s_coeff_tready;
    logic          bypass_req_i;
    logic [CB-1:0] coeff_dat_o;
    logic          coeff_wr_o;
    logic          coeff_update_o;
    logic          bypass_o;
    logic          busy_o;
    logic          done_o;
    logic          err_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit armed = 1'b0;

    // Reference model state.
    ev_t           exq[$];
    logic [CB-1:0] cur[$];
    int            busy_until = -1;
    logic [CB-1:0] exp_dat = '0;
    logic          last_req = 1'b0;
    logic          last_rst = 1'b1;

    biquad8_coeff_sequencer #(
        .NCOEFF       (NC),
        .COEFF_BITS   (CB),
        .SETTLE_CYCLES(SC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_coeff_tdata (s_coeff_tdata),
        .s_coeff_tvalid(s_coeff_tvalid),
        .s_coeff_tlast (s_coeff_tlast),
        .s_coeff_tready(s_coeff_tready),
        .bypass_req_i  (bypass_req_i),
        .coeff_dat_o   (coeff_dat_o),
        .coeff_wr_o    (coeff_wr_o),
        .coeff_update_o(coeff_update_o),
        .bypass_o      (bypass_o),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .err_o         (err_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Monitor: compares DUT behaviour each cycle against the model.
    always @(negedge clk) begin
        if (armed) begin
            int n;
            int kind;
            n = int'(coeff_wr_o) + int'(coeff_update_o) + int'(done_o) + int'(err_o);
            kind = coeff_wr_o ? KWr : coeff_update_o ? KUpd : done_o ? KDone : KErr;

            // Expected events whose cycle has passed without being seen.
            while (exq.size() > 0 && exq[0].cyc < cyc) begin
                ev_t m;
                m = exq.pop_front();
                chk("missed_event_kind", 32'(m.kind), 32'hFFFF);
            end

            if (coeff_wr_o && coeff_update_o) chk("wr_and_update", 32'd1, 32'd0);
            if (n > 1) begin
                chk("strobe_count", 32'(n), 32'd1);
            end else if (n == 1) begin
                if (exq.size() == 0) begin
                    chk("unexpected_event_kind", 32'(kind), 32'hFFFF);
                end else begin
                    ev_t e;
                    e = exq.pop_front();
                    chk("event_kind", 32'(kind), 32'(e.kind));
                    chk("event_cycle", 32'(cyc), 32'(e.cyc));
                    if (kind == KWr) begin
                        chk("wr_data", 32'(coeff_dat_o), 32'(e.dat));
                        exp_dat = e.dat;
                    end
                end
            end

            chk("tready", 32'(s_coeff_tready), 32'(!rst && !(cyc <= busy_until)));
            chk("busy", 32'(busy_o), 32'(cyc <= busy_until));
            if (!coeff_wr_o) chk("dat_hold", 32'(coeff_dat_o), 32'(exp_dat));
            chk("bypass", 32'(bypass_o), 32'(last_rst ? 1'b1 : last_req));

            // Word-level model: a set of exactly NC words commits, anything else errors.
            if (s_coeff_tvalid && s_coeff_tready) begin
                cur.push_back(s_coeff_tdata);
                if (s_coeff_tlast) begin
                    if (cur.size() == NC) begin
                        for (int k = 0; k < NC; k++) exq.push_back('{cyc + 1 + k, KWr, cur[k]});
                        exq.push_back('{cyc + NC + 1, KUpd, '0});
                        exq.push_back('{cyc + NC + 1 + SC, KDone, '0});
                        busy_until = cyc + NC + 1 + SC;
                    end else begin
                        exq.push_back('{cyc + 1, KErr, '0});
                    end
                    cur.delete();
                end
            end

            if (rst) begin
                exq.delete();
                cur.delete();
                busy_until = cyc;
                exp_dat = '0;
            end
            last_req = bypass_req_i;
            last_rst = rst;
        end
    end

    // Independent bypass request toggling.
    initial begin
        bypass_req_i = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if ($urandom_range(0, 3) == 0) bypass_req_i = ~bypass_req_i;
        end
    end

    task automatic send_word(input logic [CB-1:0] d, input logic l);
        int n;
        s_coeff_tdata  = d;
        s_coeff_tlast  = l;
        s_coeff_tvalid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!s_coeff_tready && n < 200);
        if (!s_coeff_tready) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        s_coeff_tvalid = 1'b0;
        s_coeff_tlast  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst            = 1'b1;
        s_coeff_tdata  = '0;
        s_coeff_tvalid = 1'b0;
        s_coeff_tlast  = 1'b0;
        @(posedge clk);
        #1;
        armed = 1'b1;
        idle(1);
        rst = 1'b0;
        idle(2);

        // Nominal set.
        send_word(18'h0C000, 1'b0);
        send_word(18'h02000, 1'b1);
        idle(8);

        // Short set, then a good set.
        send_word(18'h01234, 1'b1);
        send_word(18'h11111, 1'b0);
        send_word(18'h22222, 1'b1);
        idle(8);

        // Long set.
        send_word(18'h00001, 1'b0);
        send_word(18'h00002, 1'b0);
        send_word(18'h00003, 1'b1);
        idle(3);

        // Second set queued behind the first with tvalid held.
        send_word(18'h0AAAA, 1'b0);
        send_word(18'h05555, 1'b1);
        send_word(18'h3FFFF, 1'b0);
        send_word(18'h00000, 1'b1);
        idle(8);

        // Reset during WRITE.
        send_word(18'h0C000, 1'b0);
        send_word(18'h02000, 1'b1);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        idle(8);

        // Random sets of length 1..3.
        for (int s = 0; s < 40; s++) begin
            int len;
            len = $urandom_range(1, 3);
            idle($urandom_range(0, 3));
            for (int w = 0; w < len; w++) begin
                send_word(CB'($urandom), w == len - 1);
            end
        end

        idle(12);
        chk("queue_empty", 32'(exq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
